event_counter: RTL and testbench
================================

# event_counter

Free-running event counter for pipeline statistics. One count per rising clock edge while the enable input is high, presented as an unsigned registered total. The next-PC unit instantiates three copies: unconditional jumps, taken conditional branches, and conditional branches. In that instantiation reset is tied low, so the counter must also come up at zero without reset.

## Interface
Parameters:
- WIDTH, default 16: counter and output width in bits; legal range 2..32.

Ports, in positional order (the first four are the order the next-PC unit instantiates positionally):
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  reset, synchronous and active-high; clears count on the next rising clk.
- en  input  1  count enable, level-sensitive, sampled at rising clk.
- count  output  WIDTH  current event total, unsigned, registered.
- wrap  output  1  one-cycle registered pulse; high in the cycle after the counter passes its maximum value. Trailing port, may be left unconnected.

## Operation
- Each rising clk, in priority order:
  - rst=1: count←0 and wrap←0, regardless of en.
  - else en=1 and count<max: count←count+1, wrap←0.
  - else en=1 and count=max (2^WIDTH−1): default build sets count←0, wrap←1. Saturating build: see Configuration.
  - else (en=0): count holds, wrap←0.
- en held high for N consecutive edges advances count by exactly N, modulo 2^WIDTH. One increment per edge, never more.
- Arithmetic is unsigned and WIDTH bits wide. No carry out beyond wrap.
- Power-up value: count=0 and wrap=0 via register initial value. This is required because rst may be permanently tied low.
- en and rst are synchronous inputs. A change between edges has no effect until the next edge.

## Timing
- Latency: count reflects en sampled at edge k immediately after edge k (one-cycle registered).
- Reset takes effect at the first rising clk with rst=1. count reads 0 from then on while rst stays high.
- Reset mid-count: the accumulated total is discarded. The first enabled edge after rst deasserts yields count=1.
- Simultaneous rst=1 and en=1: reset wins and count=0.
- wrap is high for exactly one cycle per overflow. With en held high it recurs every 2^WIDTH edges.
- Outputs are driven only by registers, with no combinational path from en or rst to count.

## Configuration
- Macro EVENT_COUNTER_SATURATE_EN.
- Undefined (default): at max, an enabled edge wraps count to 0 and pulses wrap.
- Defined: at max, an enabled edge holds count at 2^WIDTH−1. wrap is then a sticky saturation flag: set on the first enabled edge at max, cleared only by rst.

## Structure
- Shared package event_counter_pkg: default-width constant (16), the maximum-value function/constant derived from WIDTH, and a count_t typedef for the default width.
- No sub-module. Single register process plus next-state logic.
- Optional simulation assertions (e.g. count never exceeds max in the saturating build) are guarded by the team's standard simulation guard.

## Test plan
- Power-up, rst=0, en=0 for 5 cycles → count=0, wrap=0 throughout.
- en=1 for 10 edges then en=0 for 3 → count=10 after the 10th edge, holds 10.
- count=7, drive rst=1 and en=1 on the same edge → count=0. Release rst with en=1 → count=1 after the next edge.
- Preload by counting to 0xFFFE (WIDTH=16), en=1 for 2 edges → 0xFFFF, then 0x0000 with wrap=1 for one cycle only.
- Same as above with EVENT_COUNTER_SATURATE_EN defined → count stays 0xFFFF, wrap=1 and stays 1 until rst.
- WIDTH=4, en toggling 1,0,1,1,0,1 → count sequence 1,1,2,3,3,4.

Source files
------------

// File: rtl/event_counter_pkg.sv
// event_counter_pkg: shared width default, count type and max-value helper for event_counter.
package event_counter_pkg;
    localparam int DEFAULT_WIDTH = 16;
    typedef logic [DEFAULT_WIDTH-1:0] count_t;
    function automatic logic [31:0] max_count(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/event_counter.sv
// event_counter: registered event total with overflow pulse, or sticky saturation flag
// when EVENT_COUNTER_SATURATE_EN is defined.
module event_counter
    import event_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));
    // Initialisers give the zero power-up state, since rst may be tied low.
    logic [WIDTH-1:0] count_q = '0;
    logic             wrap_q  = 1'b0;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             at_max;
    always_comb begin
        at_max = count_q == MAX;
`ifdef EVENT_COUNTER_SATURATE_EN
        count_d = rst ? '0 : (!en || at_max) ? count_q : count_q + WIDTH'(1);
        wrap_d  = !rst && (wrap_q || (en && at_max));
`else
        count_d = rst ? '0 : !en ? count_q : at_max ? '0 : count_q + WIDTH'(1);
        wrap_d  = !rst && en && at_max;
`endif
    end
    always_ff @(posedge clk) begin
        count_q <= count_d;
        wrap_q  <= wrap_d;
    end
    assign count = count_q;
    assign wrap  = wrap_q;
`ifndef SYNTHESIS
`ifdef EVENT_COUNTER_SATURATE_EN
    always_ff @(posedge clk) begin
        if (wrap_q) assert (count_q == MAX) else $error("saturation flag set below max");
    end
`endif
`endif
endmodule

// File: tb/tb_event_counter.sv
// tb_event_counter: directed checks of event_counter at WIDTH=16 and WIDTH=4,
// expectations switch with EVENT_COUNTER_SATURATE_EN.
module tb_event_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en16 = 1'b0;
    logic        en4 = 1'b0;
    logic [15:0] count16;
    logic [3:0]  count4;
    logic        wrap16;
    logic        wrap4;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    event_counter #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .en(en16), .count(count16), .wrap(wrap16));
    event_counter #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .en(en4),  .count(count4),  .wrap(wrap4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef EVENT_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    initial begin
        int seq_en[6] = '{1, 0, 1, 1, 0, 1};
        int seq_ex[6] = '{1, 1, 2, 3, 3, 4};
        #1;
        chk("pwr_cnt", 32'(count16), 0);
        chk("pwr_wrap", 32'(wrap16), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_cnt", 32'(count16), 0);
            chk("idle_wrap", 32'(wrap16), 0);
            chk("idle_cnt4", 32'(count4), 0);
        end
        en16 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("run_cnt", 32'(count16), 32'(i));
        end
        en16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_cnt", 32'(count16), 10);
        end
        rst = 1'b1;
        step();
        chk("rst_cnt", 32'(count16), 0);
        rst = 1'b0;
        en16 = 1'b1;
        repeat (7) step();
        chk("pre7_cnt", 32'(count16), 7);
        rst = 1'b1;
        step();
        chk("rst_en_cnt", 32'(count16), 0);
        chk("rst_en_wrap", 32'(wrap16), 0);
        rst = 1'b0;
        step();
        chk("rel_cnt", 32'(count16), 1);
        repeat (16'hFFFD) step();
        chk("pre_fffe", 32'(count16), 32'hFFFE);
        step();
        chk("max_cnt", 32'(count16), 32'hFFFF);
        chk("max_wrap", 32'(wrap16), 0);
        step();
        chk("ovf_cnt", 32'(count16), SAT ? 32'hFFFF : 32'h0);
        chk("ovf_wrap", 32'(wrap16), 1);
        en16 = 1'b0;
        step();
        chk("post_cnt", 32'(count16), SAT ? 32'hFFFF : 32'h0);
        chk("post_wrap", 32'(wrap16), SAT ? 1 : 0);
        en16 = 1'b1;
        step();
        chk("post2_cnt", 32'(count16), SAT ? 32'hFFFF : 32'h1);
        chk("post2_wrap", 32'(wrap16), SAT ? 1 : 0);
        rst = 1'b1;
        step();
        chk("clr_cnt", 32'(count16), 0);
        chk("clr_wrap", 32'(wrap16), 0);
        rst = 1'b0;
        en16 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en4 = seq_en[i][0];
            step();
            chk("w4_seq", 32'(count4), 32'(seq_ex[i]));
        end
        en4 = 1'b1;
        repeat (11) step();
        chk("w4_max", 32'(count4), 15);
        chk("w4_max_wrap", 32'(wrap4), 0);
        step();
        chk("w4_ovf", 32'(count4), SAT ? 15 : 0);
        chk("w4_ovf_wrap", 32'(wrap4), 1);
        step();
        chk("w4_next", 32'(count4), SAT ? 15 : 1);
        chk("w4_next_wrap", 32'(wrap4), SAT ? 1 : 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
